gam_node_update_ctrl: RTL
=========================

// Module: gam_node_update_ctrl
// PURPOSE
//  Sequences one winner-node learning update through the calculate_W_Th datapath.
//  Per request: read winner node record (Ws1, Ws2, Ths1, Ms1) from node memory,
//  present record + X + min1_ED to the datapath, latch results, write back with Ms1+1.
//  Sits between the GAM winner-search stage (requester) and node memory. One update in flight.
// PARAMETERS
//  VECTOR_LEN  8   number of 8-bit features per node vector (matches GAM_package)
//  ADDR_W      6   node memory address width
//  RD_LAT      1   node memory read latency, cycles (>=1)
//  MS_MAX      255 saturation value of per-node win count Ms1
// PORTS
//  clk          in   1             clock, rising edge
//  rst_n        in   1             async active-low reset
//  req_valid    in   1             update request valid
//  req_ready    out  1             high only in IDLE
//  x_in         in   VECTOR_LEN*8  input vector X
//  win_idx      in   ADDR_W        winner node address
//  min1_ed      in   32            winner distance (int)
//  mem_rd_en    out  1             node memory read strobe
//  mem_wr_en    out  1             node memory write strobe
//  mem_addr     out  ADDR_W        read/write address
//  mem_rd_ws1/_ws2 in VECTOR_LEN*8 read data, weights
//  mem_rd_ths1/_ms1 in 32          read data, threshold / win count
//  mem_wr_ws1/_ws2 out VECTOR_LEN*8 write data, weights
//  mem_wr_ths1/_ms1 out 32         write data, threshold / win count
//  dp_x, dp_ws1, dp_ws2 out VECTOR_LEN*8  datapath operands (held stable from CALC onward)
//  dp_ths1, dp_ms1, dp_min1 out 32        datapath operands
//  dp_ws1_new, dp_ws2_new in VECTOR_LEN*8 datapath results (combinational)
//  dp_ths1_new  in   32            datapath threshold result
//  done         out  1             one-cycle pulse: write-back finished
//  busy         out  1             high when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; mem_rd_en=mem_wr_en=done=busy=0; all data/addr outputs=0.
//  Accept on req_valid&&req_ready: latch x_in, win_idx, min1_ed; go RD. Inputs ignored otherwise.
//  FSM: IDLE -> RD (mem_rd_en=1, mem_addr=win_idx, 1 cycle) -> WAIT (RD_LAT cycles, counter)
//       -> CALC (capture mem_rd_* into operand regs, drive dp_*; 1 cycle)
//       -> WB (latch dp_*_new into mem_wr_*, mem_wr_en=1, 1 cycle) -> DONE (done=1) -> IDLE.
//  Latency: accept edge to done pulse = RD_LAT+4 cycles; next accept possible cycle after DONE.
//  dp_ms1 = max(mem_rd_ms1,1): Ms1=0 never reaches datapath divider.
//  mem_wr_ms1 = (mem_rd_ms1>=MS_MAX) ? MS_MAX : mem_rd_ms1+1 (saturating, no wrap).
//  Weight write data is exactly datapath result; controller performs no arithmetic on weights.
//  mem_addr held at win_idx from RD through WB; mem_rd_en and mem_wr_en never both high.
//  Reset asserted mid-update: immediate return to IDLE, strobes drop, no partial write issued.
//  req_valid held high during busy: not accepted until IDLE; no request queued or lost.
// CONFIGURATION
//  GAM_NODE_INSERT_EN defined: in CALC, if min1_ed > mem_rd_ths1, WB writes a new node
//   at free_ptr (ADDR_W counter, reset 0) instead: Ws1=Ws2=X, Ths1=min1_ed, Ms1=1;
//   free_ptr increments; at 2**ADDR_W-1 it saturates, extra port mem_full=1, and
//   further inserts fall back to normal update of winner.
//  Undefined: no free_ptr, no mem_full port; winner always updated.
// TESTING
//  T1 VECTOR_LEN=1: X=120,Ws1=100,Ws2=100,Ths1=50,Ms1=4,min1_ed=30 -> wr Ws1=105,Ws2=100,Ths1=40,Ms1=5.
//  T2 reset mid-WAIT (RD_LAT=3) -> no mem_wr_en pulse, req_ready=1 next cycle, all outputs 0.
//  T3 mem_rd_ms1=255 (MS_MAX) -> mem_wr_ms1=255; mem_rd_ms1=0 -> dp_ms1=1, mem_wr_ms1=1.
//  T4 back-to-back req_valid held high, RD_LAT=1 -> done every 6 cycles, two distinct writes.
//  T5 req_valid during busy with new win_idx=7 -> ignored until IDLE, then processed with addr 7.
//  T6 GAM_NODE_INSERT_EN, min1_ed=90>Ths1=50 -> write at addr 0: Ws1=Ws2=X,Ths1=90,Ms1=1; free_ptr=1.

Source files
------------

// File: rtl/gam_node_update_ctrl_if.sv
// Signal bundle for gam_node_update_ctrl: request handshake, node-memory bus and
// calculate_W_Th datapath operands/results.
// slave  : the controller side.
// master : requester, node memory and datapath side.
// Optional macro GAM_NODE_INSERT_EN adds the mem_full status signal.
interface gam_node_update_ctrl_if #(
    parameter int VECTOR_LEN = 8,
    parameter int ADDR_W     = 6
);
    localparam int VW = VECTOR_LEN * 8;

    logic              req_valid;
    logic              req_ready;
    logic [VW-1:0]     x_in;
    logic [ADDR_W-1:0] win_idx;
    logic [31:0]       min1_ed;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [VW-1:0]     mem_rd_ws1;
    logic [VW-1:0]     mem_rd_ws2;
    logic [31:0]       mem_rd_ths1;
    logic [31:0]       mem_rd_ms1;
    logic [VW-1:0]     mem_wr_ws1;
    logic [VW-1:0]     mem_wr_ws2;
    logic [31:0]       mem_wr_ths1;
    logic [31:0]       mem_wr_ms1;

    logic [VW-1:0]     dp_x;
    logic [VW-1:0]     dp_ws1;
    logic [VW-1:0]     dp_ws2;
    logic [31:0]       dp_ths1;
    logic [31:0]       dp_ms1;
    logic [31:0]       dp_min1;
    logic [VW-1:0]     dp_ws1_new;
    logic [VW-1:0]     dp_ws2_new;
    logic [31:0]       dp_ths1_new;

    logic              done;
    logic              busy;
`ifdef GAM_NODE_INSERT_EN
    logic              mem_full;
`endif

    modport slave (
        input  req_valid, x_in, win_idx, min1_ed,
        input  mem_rd_ws1, mem_rd_ws2, mem_rd_ths1, mem_rd_ms1,
        input  dp_ws1_new, dp_ws2_new, dp_ths1_new,
        output req_ready, mem_rd_en, mem_wr_en, mem_addr,
        output mem_wr_ws1, mem_wr_ws2, mem_wr_ths1, mem_wr_ms1,
        output dp_x, dp_ws1, dp_ws2, dp_ths1, dp_ms1, dp_min1,
`ifdef GAM_NODE_INSERT_EN
        output mem_full,
`endif
        output done, busy
    );

    modport master (
        output req_valid, x_in, win_idx, min1_ed,
        output mem_rd_ws1, mem_rd_ws2, mem_rd_ths1, mem_rd_ms1,
        output dp_ws1_new, dp_ws2_new, dp_ths1_new,
        input  req_ready, mem_rd_en, mem_wr_en, mem_addr,
        input  mem_wr_ws1, mem_wr_ws2, mem_wr_ths1, mem_wr_ms1,
        input  dp_x, dp_ws1, dp_ws2, dp_ths1, dp_ms1, dp_min1,
`ifdef GAM_NODE_INSERT_EN
        input  mem_full,
`endif
        input  done, busy
    );
endinterface

// File: rtl/gam_node_update_ctrl.sv
// Winner-node learning update sequencer: reads the winner record from node memory,
// presents it with X and min1_ED to the calculate_W_Th datapath, and writes the
// results back with a saturating win count. One update in flight at a time.
// Optional macro GAM_NODE_INSERT_EN: a winner farther than its threshold spawns a
// new node at free_ptr instead of being updated, until the memory is full.
// VECTOR_LEN and ADDR_W must match the parameters of the connected interface.
module gam_node_update_ctrl #(
    parameter int VECTOR_LEN = 8,
    parameter int ADDR_W     = 6,
    parameter int RD_LAT     = 1,
    parameter int MS_MAX     = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gam_node_update_ctrl_if.slave bus
);
    localparam int                VW       = VECTOR_LEN * 8;
    localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [31:0]       MS_MAX_W = 32'(MS_MAX);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CALC, S_WB, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              wait_last;
    logic [ADDR_W-1:0] addr_q;
    logic [VW-1:0]     x_q, ws1_q, ws2_q, wr_ws1_q, wr_ws2_q;
    logic [31:0]       min1_q, ths1_q, ms1_q, ms1_inc_q, wr_ths1_q, wr_ms1_q;

    assign wait_last = (wait_cnt_q == CNT_LAST);

`ifdef GAM_NODE_INSERT_EN
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    logic [ADDR_W-1:0] free_ptr_q;
    logic              do_insert;

    // A winner outside its own threshold becomes a new node while space remains.
    assign do_insert    = ($signed(min1_q) > $signed(ths1_q)) && (free_ptr_q != PTR_MAX);
    assign bus.mem_full = (free_ptr_q == PTR_MAX);
`endif

    // Next-state and strobe decode from the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = S_RD;
            end
            S_RD: begin
                bus.mem_rd_en = 1'b1;
                state_d       = S_WAIT;
            end
            S_WAIT: if (wait_last) state_d = S_CALC;
            S_CALC: state_d = S_WB;
            S_WB: begin
                bus.mem_wr_en = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any update in flight, so no write can follow.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Request capture, read-latency count, operand capture and write-data latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            addr_q     <= '0;
            x_q        <= '0;
            min1_q     <= '0;
            ws1_q      <= '0;
            ws2_q      <= '0;
            ths1_q     <= '0;
            ms1_q      <= '0;
            ms1_inc_q  <= '0;
            wr_ws1_q   <= '0;
            wr_ws2_q   <= '0;
            wr_ths1_q  <= '0;
            wr_ms1_q   <= '0;
`ifdef GAM_NODE_INSERT_EN
            free_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    x_q    <= bus.x_in;
                    addr_q <= bus.win_idx;
                    min1_q <= bus.min1_ed;
                end
                S_RD: wait_cnt_q <= '0;
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (wait_last) begin
                        ws1_q     <= bus.mem_rd_ws1;
                        ws2_q     <= bus.mem_rd_ws2;
                        ths1_q    <= bus.mem_rd_ths1;
                        // Ms1=0 is clamped so the datapath divider never sees zero.
                        ms1_q     <= (bus.mem_rd_ms1 == 32'd0) ? 32'd1 : bus.mem_rd_ms1;
                        ms1_inc_q <= (bus.mem_rd_ms1 >= MS_MAX_W) ? MS_MAX_W
                                                                  : bus.mem_rd_ms1 + 32'd1;
                    end
                end
                S_CALC: begin
`ifdef GAM_NODE_INSERT_EN
                    if (do_insert) begin
                        wr_ws1_q   <= x_q;
                        wr_ws2_q   <= x_q;
                        wr_ths1_q  <= min1_q;
                        wr_ms1_q   <= 32'd1;
                        addr_q     <= free_ptr_q;
                        free_ptr_q <= free_ptr_q + 1'b1;
                    end else
`endif
                    begin
                        wr_ws1_q  <= bus.dp_ws1_new;
                        wr_ws2_q  <= bus.dp_ws2_new;
                        wr_ths1_q <= bus.dp_ths1_new;
                        wr_ms1_q  <= ms1_inc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_ws1  = wr_ws1_q;
    assign bus.mem_wr_ws2  = wr_ws2_q;
    assign bus.mem_wr_ths1 = wr_ths1_q;
    assign bus.mem_wr_ms1  = wr_ms1_q;
    assign bus.dp_x        = x_q;
    assign bus.dp_ws1      = ws1_q;
    assign bus.dp_ws2      = ws2_q;
    assign bus.dp_ths1     = ths1_q;
    assign bus.dp_ms1      = ms1_q;
    assign bus.dp_min1     = min1_q;
endmodule
